// File: rtl/calc_pkg.sv
// Shared constants for the calculator result path: phase codes, capture states, 7-seg glyphs.
package calc_pkg;

  // Sequence-counter values that carry the low and high result bytes
  localparam logic [2:0] PH_LO = 3'd6;
  localparam logic [2:0] PH_HI = 3'd0;

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } cap_state_t;

  // Active-high {g,f,e,d,c,b,a}; index 0 is the rightmost entry
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high 7-segment glyph.
module hex7seg
  import calc_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/result_display.sv
// Captures the calculator's two-byte result off its phase-sequenced bus and
// multiplexes it onto a 4-digit 7-segment display with status on the decimal points.
module result_display
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  phase_in,
  input  logic [7:0]  data_in,
  input  logic [4:0]  status_in,
  output logic [15:0] result,
  output logic [4:0]  status,
  output logic        result_valid,
  output logic        seq_err,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  dig_en
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  cap_state_t  state, state_nx;
  logic [7:0]  lo_byte, lo_byte_nx;
  logic [4:0]  pend_status, pend_status_nx;
  logic [15:0] result_nx;
  logic [4:0]  status_nx;
  logic        result_valid_nx;
  logic        seq_err_nx;

  logic [15:0] div_cnt;
  logic [1:0]  dig_idx;
  logic [3:0]  nibble;

  // Capture FSM: state and committed outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_LO;
      lo_byte      <= '0;
      pend_status  <= '0;
      result       <= '0;
      status       <= '0;
      result_valid <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      state        <= state_nx;
      lo_byte      <= lo_byte_nx;
      pend_status  <= pend_status_nx;
      result       <= result_nx;
      status       <= status_nx;
      result_valid <= result_valid_nx;
      seq_err      <= seq_err_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    lo_byte_nx      = lo_byte;
    pend_status_nx  = pend_status;
    result_nx       = result;
    status_nx       = status;
    result_valid_nx = 1'b0;
    seq_err_nx      = 1'b0;
    case (state)
      WAIT_LO: begin
        if (phase_in == PH_LO) begin
          lo_byte_nx     = data_in;
          pend_status_nx = status_in;
          state_nx       = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (phase_in == PH_HI) begin
          result_nx       = {data_in, lo_byte};
          status_nx       = pend_status;
          result_valid_nx = 1'b1;
          state_nx        = WAIT_LO;
        end else begin
          seq_err_nx = 1'b1;
          // A fresh low-byte phase restarts the capture in the same cycle as the abort
          if (phase_in == PH_LO) begin
            lo_byte_nx     = data_in;
            pend_status_nx = status_in;
            state_nx       = WAIT_HI;
          end else begin
            lo_byte_nx     = '0;
            pend_status_nx = '0;
            state_nx       = WAIT_LO;
          end
        end
      end
      default: state_nx = WAIT_LO;
    endcase
  end

  // Digit scan: dwell SCAN_DIV cycles per digit, then advance
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Display is driven only from committed registers, never from the input bus
  assign nibble = result[{dig_idx, 2'b00} +: 4];
  assign dig_en = 4'b0001 << dig_idx;
  assign dp     = status[4] | status[dig_idx];

  hex7seg u_hex7seg (
    .hex (nibble),
    .seg (seg)
  );

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display: capture sequencing, reset, scan and a calculator-style stream.
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  phase_in;
  logic [7:0]  data_in;
  logic [4:0]  status_in;
  logic [15:0] result;
  logic [4:0]  status;
  logic        result_valid;
  logic        seq_err;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  result_display #(.SCAN_DIV(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .phase_in     (phase_in),
    .data_in      (data_in),
    .status_in    (status_in),
    .result       (result),
    .status       (status),
    .result_valid (result_valid),
    .seq_err      (seq_err),
    .seg          (seg),
    .dp           (dp),
    .dig_en       (dig_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ph, input logic [7:0] d, input logic [4:0] st);
    phase_in  = ph;
    data_in   = d;
    status_in = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, commit 0xBEEF with the given status, then follow the scan for two full rotations
  task automatic run_scan(input logic [4:0] st);
    logic [15:0] val;
    int d;
    val = 16'hBEEF;
    rst = 1'b1;
    drive(3'd7, 8'h00, 5'h00);
    tick();
    rst = 1'b0;
    drive(3'd6, 8'hEF, st);
    tick();
    chk("scan_partial_seg", {25'd0, seg}, 32'h3F);
    chk("scan_partial_dig", {28'd0, dig_en}, 32'h1);
    drive(3'd0, 8'hBE, 5'h00);
    tick();
    drive(3'd7, 8'h00, 5'h00);
    for (int k = 0; k < 8; k++) begin
      d = (1 + k / 2) % 4;
      chk("scan_dig_en", {28'd0, dig_en}, 32'(4'b0001 << d));
      chk("scan_seg", {25'd0, seg}, {25'd0, glyph[val[4*d +: 4]]});
      chk("scan_dp", {31'd0, dp}, {31'd0, st[4] | st[d]});
      tick();
    end
  endtask

  initial begin
    logic [15:0] exp_val;
    logic [4:0]  exp_st;
    int          err_seen;
    int          vld_seen;

    rst = 1'b1;
    drive(3'd7, 8'h00, 5'h00);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_result", {16'd0, result}, 32'h0);
    chk("rst_status", {27'd0, status}, 32'h0);
    chk("rst_valid", {31'd0, result_valid}, 32'h0);
    chk("rst_seq_err", {31'd0, seq_err}, 32'h0);
    chk("rst_dig_en", {28'd0, dig_en}, 32'h1);
    chk("rst_seg", {25'd0, seg}, 32'h3F);
    chk("rst_dp", {31'd0, dp}, 32'h0);

    // Basic commit: low 0x34 with status 0x01, then high 0x12
    drive(3'd6, 8'h34, 5'h01);
    tick();
    chk("commit_no_early_valid", {31'd0, result_valid}, 32'h0);
    drive(3'd0, 8'h12, 5'h1F);
    tick();
    chk("commit_result", {16'd0, result}, 32'h1234);
    chk("commit_status", {27'd0, status}, 32'h01);
    chk("commit_valid", {31'd0, result_valid}, 32'h1);
    drive(3'd7, 8'h00, 5'h00);
    tick();
    chk("commit_valid_drop", {31'd0, result_valid}, 32'h0);

    // Abort by a stray phase
    drive(3'd6, 8'hAA, 5'h04);
    tick();
    drive(3'd1, 8'h99, 5'h00);
    tick();
    chk("abort_seq_err", {31'd0, seq_err}, 32'h1);
    chk("abort_result_held", {16'd0, result}, 32'h1234);
    chk("abort_no_valid", {31'd0, result_valid}, 32'h0);
    drive(3'd7, 8'h00, 5'h00);
    tick();
    chk("abort_seq_err_drop", {31'd0, seq_err}, 32'h0);
    chk("abort_status_held", {27'd0, status}, 32'h01);

    // Abort and restart in the same cycle
    drive(3'd6, 8'h11, 5'h02);
    tick();
    drive(3'd6, 8'h22, 5'h03);
    tick();
    chk("restart_seq_err", {31'd0, seq_err}, 32'h1);
    drive(3'd0, 8'h33, 5'h00);
    tick();
    chk("restart_result", {16'd0, result}, 32'h3322);
    chk("restart_status", {27'd0, status}, 32'h03);
    chk("restart_valid", {31'd0, result_valid}, 32'h1);
    chk("restart_no_seq_err", {31'd0, seq_err}, 32'h0);

    // Reset during WAIT_HI dominates a simultaneous high phase
    drive(3'd6, 8'h77, 5'h05);
    tick();
    rst = 1'b1;
    drive(3'd0, 8'h55, 5'h00);
    tick();
    chk("rstmid_result", {16'd0, result}, 32'h0);
    chk("rstmid_valid", {31'd0, result_valid}, 32'h0);
    chk("rstmid_seq_err", {31'd0, seq_err}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rstmid_after_result", {16'd0, result}, 32'h0);
    chk("rstmid_after_valid", {31'd0, result_valid}, 32'h0);
    chk("rstmid_after_seq_err", {31'd0, seq_err}, 32'h0);

    run_scan(5'h12);
    run_scan(5'h02);

    // Calculator stream: phases 1..6,0 repeated with random operands
    rst = 1'b1;
    drive(3'd7, 8'h00, 5'h00);
    tick();
    rst = 1'b0;
    err_seen = 0;
    vld_seen = 0;
    for (int n = 0; n < 50; n++) begin
      exp_val = 16'($urandom);
      exp_st  = 5'($urandom);
      for (int p = 1; p <= 5; p++) begin
        drive(3'(p), 8'($urandom), 5'($urandom));
        tick();
        err_seen += int'(seq_err);
        vld_seen += int'(result_valid);
      end
      drive(3'd6, exp_val[7:0], exp_st);
      tick();
      err_seen += int'(seq_err);
      vld_seen += int'(result_valid);
      drive(3'd0, exp_val[15:8], 5'($urandom));
      tick();
      err_seen += int'(seq_err);
      chk("stream_result", {16'd0, result}, {16'd0, exp_val});
      chk("stream_status", {27'd0, status}, {27'd0, exp_st});
      chk("stream_valid", {31'd0, result_valid}, 32'h1);
    end
    chk("stream_seq_err_count", err_seen, 0);
    chk("stream_stray_valid_count", vld_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per digit dwell; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port phase_in  input  3  calculator sequence counter (calculator uo_out[7:5]).
REQ-005 SHALL have port data_in  input  8  calculator result byte bus (calculator uio_out).
REQ-006 SHALL have port status_in  input  5  calculator ALU status (calculator uo_out[4:0]).
REQ-007 SHALL have port result  output  16  last committed result.
REQ-008 SHALL have port status  output  5  status committed with result.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse per committed result.
REQ-010 SHALL have port seq_err  output  1  one-cycle pulse when a started capture is aborted.
REQ-011 SHALL have port seg  output  7  active-high segments {g,f,e,d,c,b,a} of selected digit.
REQ-012 SHALL have port dp  output  1  active-high decimal point of selected digit.
REQ-013 SHALL have port dig_en  output  4  one-hot active-high digit enable; bit 0 = least significant nibble.

Function
REQ-014 SHALL implement capture FSM with states WAIT_LO and WAIT_HI, sampling inputs at every rising clk.
REQ-015 In WAIT_LO with phase_in==6: SHALL latch data_in as low byte, status_in as pending status, go to WAIT_HI; other phases: stay.
REQ-016 In WAIT_HI with phase_in==0: SHALL commit result={data_in, low byte}, status=pending status, go to WAIT_LO.
REQ-017 result, status and result_valid=1 SHALL all appear one cycle after the committing edge; result_valid low otherwise.
REQ-018 In WAIT_HI with phase_in not 0: SHALL discard partial capture, pulse seq_err one cycle, leave result/status unchanged.
REQ-019 Abort with phase_in==6 in same cycle: SHALL relatch low byte/status and remain in WAIT_HI (abort and restart simultaneous).
REQ-020 result and status SHALL hold until next commit; back-to-back commits SHALL each produce their own pulse.
REQ-021 Scan: divider counts 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-022 dig_en SHALL equal one-hot of digit index; seg SHALL be hex decode (0-F, standard 7-seg glyphs) of result nibble [4*i+3:4*i].
REQ-023 dp SHALL equal status[i] for digit i; status[4] SHALL light dp on all digits.
REQ-024 Display SHALL reflect committed result only, never partial capture; new commit visible on the current digit the cycle result updates.

Reset
REQ-025 On rst: FSM=WAIT_LO, result=0, status=0, pending regs=0, result_valid=0, seq_err=0, divider=0, digit index=0.
REQ-026 After reset outputs SHALL be dig_en=0001, seg=0111111 ("0"), dp=0.
REQ-027 rst mid-capture (WAIT_HI) SHALL drop the partial result with no seq_err pulse; rst SHALL dominate all other events.

Structure
REQ-028 calc_pkg SHALL hold phase constants PH_LO=3'd6, PH_HI=3'd0, FSM state encoding, and the 16-entry hex-to-segment table.
REQ-029 Hex decode SHALL be a separate combinational sub-module hex7seg (4-bit in, 7-bit out).
REQ-030 Capture FSM and scan counter SHALL be independent processes; no combinational path data_in->seg.

Verification
REQ-031 Phase sequence 6 (data 0x34, status 0x01) then 0 (data 0x12) -> next cycle result=0x1234, status=0x01, one result_valid pulse.
REQ-032 Phase 6 (0xAA) then 1 -> seq_err single pulse, result unchanged, no result_valid.
REQ-033 Phase 6 (0x11), 6 (0x22), 0 (0x33) -> seq_err pulse, then result=0x3322.
REQ-034 rst asserted in WAIT_HI, then phase 0 with data 0x55 -> no commit, no seq_err, result=0.
REQ-035 SCAN_DIV=2, result=0xBEEF, status=0x12 -> dig_en cycles 0001,0010,0100,1000 every 2 clks, seg F,E,E,b glyphs, dp on digit 1 then all digits (status[4]).
REQ-036 Calculator model running continuous 7-phase cycles, 50 random operand sets -> every result/status matches model, zero seq_err.
